// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative left shifter.
// The optional early-exit latency mode is selected with SHIFT_LEFT_EARLY_EXIT_EN.
package shift_pkg;

  localparam int N           = 32;
  localparam int SHAMT_BITS  = 5;
  localparam int STAGE_COUNT = 5;
  localparam int K_BITS      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_left_stage.sv
// One binary shift stage: word << 2^k with zero fill when enabled, else pass-through.
module shift_left_stage
  import shift_pkg::*;
(
  input  logic [N-1:0]      word,
  input  logic [K_BITS-1:0] k,
  input  logic              en,
  output logic [N-1:0]      shifted
);

  always_comb begin
    shifted = word;
    if (en) begin
      case (k)
        3'd0:    shifted = word << 1;
        3'd1:    shifted = word << 2;
        3'd2:    shifted = word << 4;
        3'd3:    shifted = word << 8;
        3'd4:    shifted = word << 16;
        default: shifted = word;
      endcase
    end
  end

endmodule

// File: rtl/shift_left_iterative.sv
// Multi-cycle logical left shifter, one binary stage per clock, valid/ready on both sides.
// Define SHIFT_LEFT_EARLY_EXIT_EN to stop once no higher shamt bits remain.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// SHIFT | applying stage k (shift by 2^k when shamt[k] is set)
// DONE  | out_valid high, holding result until out_ready
module shift_left_iterative
  import shift_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic [N-1:0] shamt,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t                state_q, state_d;
  logic [N-1:0]          work_q;
  logic [SHAMT_BITS-1:0] amt_q;
  logic [K_BITS-1:0]     k_q;

  logic [N-1:0]          stage_out;
  logic                  stage_en;
  logic                  accept;
  logic                  big_amt;
  logic                  last_stage;
  logic [SHAMT_BITS-1:0] amt_rest;

  assign big_amt  = |shamt[N-1:SHAMT_BITS];
  assign stage_en = |(amt_q & (SHAMT_BITS'(1) << k_q));
  assign amt_rest = amt_q >> k_q;

`ifdef SHIFT_LEFT_EARLY_EXIT_EN
  // Finished once no shamt bits above the current stage are set.
  assign last_stage = (amt_rest[SHAMT_BITS-1:1] == '0) ||
                      (k_q == K_BITS'(STAGE_COUNT - 1));
`else
  assign last_stage = (k_q == K_BITS'(STAGE_COUNT - 1));
`endif

  shift_left_stage u_stage (
    .word    (work_q),
    .k       (k_q),
    .en      (stage_en),
    .shifted (stage_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = (state_q == DONE);
    out       = work_q;
    accept    = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (big_amt) begin
            state_d = DONE;
          end else begin
`ifdef SHIFT_LEFT_EARLY_EXIT_EN
            state_d = (shamt[SHAMT_BITS-1:0] == '0) ? DONE : SHIFT;
`else
            state_d = SHIFT;
`endif
          end
        end
      end
      SHIFT: begin
        if (last_stage) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working register doubles as the output register, so reset also clears out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      amt_q  <= '0;
      k_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            work_q <= big_amt ? '0 : in;
            amt_q  <= shamt[SHAMT_BITS-1:0];
            k_q    <= '0;
          end
        end
        SHIFT: begin
          work_q <= stage_out;
          k_q    <= k_q + K_BITS'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
